// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: decode-side hazard inputs plus the stall/flush controls it returns.
// master = pipeline datapath, slave = pipeline_hazard_ctrl.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       ifid_rs1;
   logic [4:0]       ifid_rs2;
   logic             ifid_uses_rs2;
   logic             idex_mem_read;
   logic [4:0]       idex_rd;
   logic             branch_taken;
   logic             mem_busy;
   logic             pc_write;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             idex_stall;
   logic             exmem_stall;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_mem_read, idex_rd,
             branch_taken, mem_busy,
      input  pc_write, ifid_stall, ifid_flush, idex_bubble, idex_stall,
             exmem_stall, stall_count, flush_count
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_mem_read, idex_rd,
             branch_taken, mem_busy,
      output pc_write, ifid_stall, ifid_flush, idex_bubble, idex_stall,
             exmem_stall, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, taken branch, slow data memory).
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
//
// state      | meaning
// RUN        | normal flow; single-cycle load-use bubbles handled here
// LOAD_STALL | extra load-use bubbles still owed, count held in cnt
// MEM_WAIT   | whole pipeline frozen on mem_busy; ret_state is where to resume
module pipeline_hazard_ctrl #(
   parameter int unsigned LOAD_USE_CYCLES = 1,
   parameter int unsigned CNT_W           = 32
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   state_t     state, state_nxt;
   state_t     ret_state, ret_nxt;
   state_t     eff_state;
   logic [1:0] cnt, cnt_nxt;
   logic       luh;
   logic       pc_write_c, ifid_stall_c, ifid_flush_c;
   logic       idex_bubble_c, idex_stall_c, exmem_stall_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         ret_state <= RUN;
         cnt       <= 2'd0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
         cnt       <= cnt_nxt;
      end
   end

   always_comb begin
      luh = hz.idex_mem_read && (hz.idex_rd != 5'd0) &&
            ((hz.idex_rd == hz.ifid_rs1) ||
             (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2)));
   end

   // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
   always_comb begin
      state_nxt     = state;
      ret_nxt       = ret_state;
      cnt_nxt       = cnt;
      pc_write_c    = 1'b1;
      ifid_stall_c  = 1'b0;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;
      idex_stall_c  = 1'b0;
      exmem_stall_c = 1'b0;
      eff_state     = (state == MEM_WAIT) ? ret_state : state;

      if (hz.mem_busy) begin
         pc_write_c    = 1'b0;
         ifid_stall_c  = 1'b1;
         idex_stall_c  = 1'b1;
         exmem_stall_c = 1'b1;
         state_nxt     = MEM_WAIT;
         ret_nxt       = eff_state;
      end else if (hz.branch_taken) begin
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
         state_nxt     = RUN;
         ret_nxt       = RUN;
         cnt_nxt       = 2'd0;
      end else if (eff_state == LOAD_STALL) begin
         pc_write_c    = 1'b0;
         ifid_stall_c  = 1'b1;
         idex_bubble_c = 1'b1;
         if (cnt <= 2'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
         end else begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = cnt - 2'd1;
         end
      end else if (luh) begin
         pc_write_c    = 1'b0;
         ifid_stall_c  = 1'b1;
         idex_bubble_c = 1'b1;
         if (LOAD_USE_CYCLES > 1) begin
            state_nxt = LOAD_STALL;
            cnt_nxt   = 2'(LOAD_USE_CYCLES - 1);
         end else begin
            state_nxt = RUN;
         end
      end else begin
         state_nxt = RUN;
      end
   end

   // Reset forces the default controls immediately, not only after the state flops clear.
   assign hz.pc_write    = reset | pc_write_c;
   assign hz.ifid_stall  = ~reset & ifid_stall_c;
   assign hz.ifid_flush  = ~reset & ifid_flush_c;
   assign hz.idex_bubble = ~reset & idex_bubble_c;
   assign hz.idex_stall  = ~reset & idex_stall_c;
   assign hz.exmem_stall = ~reset & exmem_stall_c;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write_c && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (ifid_flush_c && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign hz.stall_count = stall_q;
   assign hz.flush_count = flush_q;
`else
   assign hz.stall_count = '0;
   assign hz.flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (1 and 3 load-use bubbles) see identical directed stimulus.
module tb_pipeline_hazard_ctrl;
   localparam int unsigned CNT_W = 32;
   // {pc_write, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall}
   localparam logic [5:0] D = 6'b100000;
   localparam logic [5:0] L = 6'b010100;
   localparam logic [5:0] F = 6'b101100;
   localparam logic [5:0] Z = 6'b010011;

   typedef struct {
      string       name;
      logic [5:0]  e1;
      logic [5:0]  e3;
      logic [31:0] s1, f1, s3, f3;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   logic [31:0] m_s1 = 0, m_f1 = 0, m_s3 = 0, m_f3 = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz1 ();
   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz3 ();

   pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
      .clk(clk), .reset(reset), .hz(hz1));
   pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
      .clk(clk), .reset(reset), .hz(hz3));

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", what, act, req);
      end
   endtask

   task automatic step(input string name, input logic rst, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic br, input logic mb,
                       input logic [5:0] e1, input logic [5:0] e3);
      exp_t e;
      @(posedge clk);
      #1;
      reset             = rst;
      hz1.idex_mem_read = mr;  hz3.idex_mem_read = mr;
      hz1.idex_rd       = rd;  hz3.idex_rd       = rd;
      hz1.ifid_rs1      = rs1; hz3.ifid_rs1      = rs1;
      hz1.ifid_rs2      = rs2; hz3.ifid_rs2      = rs2;
      hz1.ifid_uses_rs2 = u2;  hz3.ifid_uses_rs2 = u2;
      hz1.branch_taken  = br;  hz3.branch_taken  = br;
      hz1.mem_busy      = mb;  hz3.mem_busy      = mb;
      if (rst) begin
         m_s1 = 0; m_f1 = 0; m_s3 = 0; m_f3 = 0;
      end
      e.name = name;
      e.e1 = e1;
      e.e3 = e3;
`ifdef HAZARD_PERF_EN
      e.s1 = m_s1; e.f1 = m_f1; e.s3 = m_s3; e.f3 = m_f3;
`else
      e.s1 = 0; e.f1 = 0; e.s3 = 0; e.f3 = 0;
`endif
      sb_q.push_back(e);
      if (!rst) begin
         if (!e1[5]) m_s1++;
         if (e1[3])  m_f1++;
         if (!e3[5]) m_s3++;
         if (e3[3])  m_f3++;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.name, "/d1_ctl"}, 32'({hz1.pc_write, hz1.ifid_stall, hz1.ifid_flush,
                                         hz1.idex_bubble, hz1.idex_stall, hz1.exmem_stall}), 32'(e.e1));
            chk({e.name, "/d3_ctl"}, 32'({hz3.pc_write, hz3.ifid_stall, hz3.ifid_flush,
                                         hz3.idex_bubble, hz3.idex_stall, hz3.exmem_stall}), 32'(e.e3));
            chk({e.name, "/d1_stall_cnt"}, hz1.stall_count, e.s1);
            chk({e.name, "/d1_flush_cnt"}, hz1.flush_count, e.f1);
            chk({e.name, "/d3_stall_cnt"}, hz3.stall_count, e.s3);
            chk({e.name, "/d3_flush_cnt"}, hz3.flush_count, e.f3);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b1;
      hz1.idex_mem_read = 0; hz1.idex_rd = 0; hz1.ifid_rs1 = 0; hz1.ifid_rs2 = 0;
      hz1.ifid_uses_rs2 = 0; hz1.branch_taken = 0; hz1.mem_busy = 0;
      hz3.idex_mem_read = 0; hz3.idex_rd = 0; hz3.ifid_rs1 = 0; hz3.ifid_rs2 = 0;
      hz3.ifid_uses_rs2 = 0; hz3.branch_taken = 0; hz3.mem_busy = 0;

      //    name          rst mr rd rs1 rs2 u2 br mb  dut1 dut3
      step("rst",          1, 0, 0, 0,  0,  0, 0, 0,  D, D);
      step("rst_busy",     1, 0, 0, 0,  0,  0, 1, 1,  D, D);
      step("idle",         0, 0, 0, 0,  0,  0, 0, 0,  D, D);
      step("lu_hit",       0, 1, 5, 5,  0,  0, 0, 0,  L, L);
      step("lu_after1",    0, 0, 0, 5,  0,  0, 0, 0,  D, L);
      step("lu_after2",    0, 0, 0, 5,  0,  0, 0, 0,  D, L);
      step("lu_done",      0, 0, 0, 5,  0,  0, 0, 0,  D, D);
      step("x0",           0, 1, 0, 0,  0,  0, 0, 0,  D, D);
      step("rs2_unused",   0, 1, 7, 3,  7,  0, 0, 0,  D, D);
      step("rs2_used",     0, 1, 7, 3,  7,  1, 0, 0,  L, L);
      step("rs2_after1",   0, 0, 0, 3,  7,  1, 0, 0,  D, L);
      step("rs2_after2",   0, 0, 0, 3,  7,  1, 0, 0,  D, L);
      step("rs2_done",     0, 0, 0, 3,  7,  1, 0, 0,  D, D);
      step("br",           0, 0, 0, 0,  0,  0, 1, 0,  F, F);
      step("br_after",     0, 0, 0, 0,  0,  0, 0, 0,  D, D);
      step("br_luh",       0, 1, 5, 5,  0,  0, 1, 0,  F, F);
      step("br_luh_after", 0, 0, 0, 0,  0,  0, 0, 0,  D, D);
      step("mb_br",        0, 0, 0, 0,  0,  0, 1, 1,  Z, Z);
      step("mb_rel_br",    0, 0, 0, 0,  0,  0, 1, 0,  F, F);
      step("mb_br_after",  0, 0, 0, 0,  0,  0, 0, 0,  D, D);

      step("rst2",         1, 0, 0, 0,  0,  0, 0, 0,  D, D);
      for (int i = 0; i < 4; i++)
         step("mem_frz",   0, 1, 5, 5,  0,  0, 0, 1,  Z, Z);
      step("mem_rel",      0, 1, 5, 5,  0,  0, 0, 0,  L, L);
      step("mem_after1",   0, 0, 0, 5,  0,  0, 0, 0,  D, L);
      step("mem_after2",   0, 0, 0, 5,  0,  0, 0, 0,  D, L);
      step("mem_done",     0, 0, 0, 5,  0,  0, 0, 0,  D, D);

      step("bo_lu",        0, 1, 5, 5,  0,  0, 0, 0,  L, L);
      step("bo_ls1",       0, 0, 0, 5,  0,  0, 0, 0,  D, L);
      step("bo_br_ls2",    0, 0, 0, 5,  0,  0, 1, 0,  F, F);
      step("bo_run",       0, 0, 0, 5,  0,  0, 0, 0,  D, D);
      step("bo2_lu",       0, 1, 5, 5,  0,  0, 0, 0,  L, L);
      step("bo2_br_ls1",   0, 0, 0, 5,  0,  0, 1, 0,  F, F);
      step("bo2_run",      0, 0, 0, 5,  0,  0, 0, 0,  D, D);

      step("ms_frz",       0, 0, 0, 0,  0,  0, 0, 1,  Z, Z);
      step("ms_rst",       1, 0, 0, 0,  0,  0, 0, 1,  D, D);
      step("ms_rst2",      1, 0, 0, 0,  0,  0, 0, 0,  D, D);
      step("ms_idle",      0, 0, 0, 0,  0,  0, 0, 0,  D, D);

      repeat (3) @(posedge clk);
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
